// File: rtl/axi4lite_stats.sv
// Passive AXI4-Lite statistics monitor.
// Counts handshakes per channel and B/R error responses. Tracks outstanding writes and reads
// with high-water marks. Raises sticky flags for VALID drops, payload changes while stalled,
// orphan responses and outstanding-counter saturation.
// All outputs come straight from flops; the block never drives the bus.
module axi4lite_stats #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned DATA_BYTEW = 4,
   parameter int unsigned ID_W       = 4,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned OST_W      = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_clr,
   // AW channel
   input  logic [ID_W-1:0]         i_axi_awid,
   input  logic [ADDR_W-1:0]       i_axi_awaddr,
   input  logic [2:0]              i_axi_awprot,
   input  logic                    i_axi_awvalid,
   input  logic                    i_axi_awready,
   // W channel
   input  logic [8*DATA_BYTEW-1:0] i_axi_wdata,
   input  logic [DATA_BYTEW-1:0]   i_axi_wstrb,
   input  logic                    i_axi_wvalid,
   input  logic                    i_axi_wready,
   // B channel
   input  logic [ID_W-1:0]         i_axi_bid,
   input  logic [1:0]              i_axi_bresp,
   input  logic                    i_axi_bvalid,
   input  logic                    i_axi_bready,
   // AR channel
   input  logic [ID_W-1:0]         i_axi_arid,
   input  logic [ADDR_W-1:0]       i_axi_araddr,
   input  logic [2:0]              i_axi_arprot,
   input  logic                    i_axi_arvalid,
   input  logic                    i_axi_arready,
   // R channel
   input  logic [ID_W-1:0]         i_axi_rid,
   input  logic [8*DATA_BYTEW-1:0] i_axi_rdata,
   input  logic [1:0]              i_axi_rresp,
   input  logic                    i_axi_rvalid,
   input  logic                    i_axi_rready,
   // Statistics
   output logic [5*CNT_W-1:0]      o_cnt_tfr,
   output logic [CNT_W-1:0]        o_cnt_berr,
   output logic [CNT_W-1:0]        o_cnt_rerr,
   output logic [OST_W-1:0]        o_wr_ost,
   output logic [OST_W-1:0]        o_rd_ost,
   output logic [OST_W-1:0]        o_wr_hwm,
   output logic [OST_W-1:0]        o_rd_hwm,
   output logic [4:0]              o_err_vlddrop,
   output logic [4:0]              o_err_unstable,
   output logic [1:0]              o_err_orphan,
   output logic [1:0]              o_err_ovf
);

   localparam int unsigned DATA_W  = 8 * DATA_BYTEW;
   localparam int unsigned AX_PL_W = ID_W + ADDR_W + 3;
   localparam int unsigned W_PL_W  = DATA_W + DATA_BYTEW;
   localparam int unsigned R_PL_W  = ID_W + DATA_W + 2;
   localparam int unsigned PL_W0   = (AX_PL_W > W_PL_W) ? AX_PL_W : W_PL_W;
   // B payload (ID_W+2) is always narrower than R, so it never sets the width
   localparam int unsigned PL_W    = (PL_W0 > R_PL_W) ? PL_W0 : R_PL_W;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [OST_W-1:0] OST_ONE = OST_W'(1);
   localparam logic [OST_W-1:0] OST_MAX = '1;

   // Channel index order everywhere: 0 AW, 1 W, 2 B, 3 AR, 4 R
   logic [4:0]       vld, rdy, tfr;
   logic [PL_W-1:0]  pl [5];

   assign vld = {i_axi_rvalid, i_axi_arvalid, i_axi_bvalid, i_axi_wvalid, i_axi_awvalid};
   assign rdy = {i_axi_rready, i_axi_arready, i_axi_bready, i_axi_wready, i_axi_awready};
   assign tfr = vld & rdy;

   // Payloads zero-extended to a common width so all channels share one stall checker
   assign pl[0] = PL_W'({i_axi_awid, i_axi_awaddr, i_axi_awprot});
   assign pl[1] = PL_W'({i_axi_wdata, i_axi_wstrb});
   assign pl[2] = PL_W'({i_axi_bid, i_axi_bresp});
   assign pl[3] = PL_W'({i_axi_arid, i_axi_araddr, i_axi_arprot});
   assign pl[4] = PL_W'({i_axi_rid, i_axi_rdata, i_axi_rresp});

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != '1)) ? v + CNT_ONE : v;
   endfunction

   // Returns {overflow, next}; dec must already be gated so it never fires at zero
   function automatic logic [OST_W:0] ost_step(input logic [OST_W-1:0] v, input logic inc,
                                               input logic dec);
      logic [OST_W-1:0] n;
      logic             ovf;
      n   = v;
      ovf = 1'b0;
      if (inc && !dec) begin
         if (v == OST_MAX) ovf = 1'b1;
         else              n   = v + OST_ONE;
      end else if (dec && !inc) begin
         n = v - OST_ONE;
      end
      return {ovf, n};
   endfunction

   logic [CNT_W-1:0] cnt_q [5];
   logic [CNT_W-1:0] berr_q, rerr_q;
   logic [OST_W-1:0] aw_ost_q, aw_ost_d, w_ost_q, w_ost_d, rd_ost_q, rd_ost_d;
   logic [OST_W-1:0] wr_hwm_q, wr_hwm_d, rd_hwm_q, rd_hwm_d;
   logic             aw_ovf, w_ovf, rd_ovf, b_orphan, r_orphan;
   logic [4:0]       stalled_q, drop_ev, unst_ev;
   logic [PL_W-1:0]  pl_q [5];
   logic [4:0]       vlddrop_q, unstable_q;
   logic [1:0]       orphan_q, ovf_q;

   // Saturating transfer and error-response counters
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < 5; k++) cnt_q[k] <= '0;
         berr_q <= '0;
         rerr_q <= '0;
      end else if (i_clr) begin
         for (int k = 0; k < 5; k++) cnt_q[k] <= '0;
         berr_q <= '0;
         rerr_q <= '0;
      end else begin
         for (int k = 0; k < 5; k++) cnt_q[k] <= sat_inc(cnt_q[k], tfr[k]);
         berr_q <= sat_inc(berr_q, tfr[2] & i_axi_bresp[1]);
         rerr_q <= sat_inc(rerr_q, tfr[4] & i_axi_rresp[1]);
      end
   end

   // Outstanding next-state, orphan/overflow detection and high-water marks
   always_comb begin
      // A response with nothing outstanding is an orphan; same-cycle requests don't excuse it
      b_orphan = tfr[2] && ((aw_ost_q == '0) || (w_ost_q == '0));
      r_orphan = tfr[4] && (rd_ost_q == '0);
      {aw_ovf, aw_ost_d} = ost_step(aw_ost_q, tfr[0], tfr[2] && (aw_ost_q != '0));
      {w_ovf, w_ost_d}   = ost_step(w_ost_q, tfr[1], tfr[2] && (w_ost_q != '0));
      {rd_ovf, rd_ost_d} = ost_step(rd_ost_q, tfr[3], tfr[4] && (rd_ost_q != '0));
      wr_hwm_d = (aw_ost_d > wr_hwm_q) ? aw_ost_d : wr_hwm_q;
      rd_hwm_d = (rd_ost_d > rd_hwm_q) ? rd_ost_d : rd_hwm_q;
   end

   // Outstanding counters keep tracking through a clear; only the marks are zeroed
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         aw_ost_q <= '0;
         w_ost_q  <= '0;
         rd_ost_q <= '0;
         wr_hwm_q <= '0;
         rd_hwm_q <= '0;
      end else begin
         aw_ost_q <= aw_ost_d;
         w_ost_q  <= w_ost_d;
         rd_ost_q <= rd_ost_d;
         wr_hwm_q <= i_clr ? '0 : wr_hwm_d;
         rd_hwm_q <= i_clr ? '0 : rd_hwm_d;
      end
   end

   // Stall tracking: remember VALID && !READY and the payload seen with it
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stalled_q <= '0;
         for (int k = 0; k < 5; k++) pl_q[k] <= '0;
      end else begin
         stalled_q <= vld & ~rdy;
         for (int k = 0; k < 5; k++) pl_q[k] <= pl[k];
      end
   end

   // Protocol events against the previous cycle's stall state
   always_comb begin
      drop_ev = stalled_q & ~vld;
      unst_ev = '0;
      for (int k = 0; k < 5; k++) begin
         unst_ev[k] = stalled_q[k] && vld[k] && (pl[k] != pl_q[k]);
      end
   end

   // Sticky flags; clear wins over events in the same cycle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vlddrop_q  <= '0;
         unstable_q <= '0;
         orphan_q   <= '0;
         ovf_q      <= '0;
      end else if (i_clr) begin
         vlddrop_q  <= '0;
         unstable_q <= '0;
         orphan_q   <= '0;
         ovf_q      <= '0;
      end else begin
         vlddrop_q  <= vlddrop_q | drop_ev;
         unstable_q <= unstable_q | unst_ev;
         orphan_q   <= orphan_q | {r_orphan, b_orphan};
         ovf_q      <= ovf_q | {rd_ovf, aw_ovf | w_ovf};
      end
   end

   assign o_cnt_tfr      = {cnt_q[4], cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
   assign o_cnt_berr     = berr_q;
   assign o_cnt_rerr     = rerr_q;
   assign o_wr_ost       = aw_ost_q;
   assign o_rd_ost       = rd_ost_q;
   assign o_wr_hwm       = wr_hwm_q;
   assign o_rd_hwm       = rd_hwm_q;
   assign o_err_vlddrop  = vlddrop_q;
   assign o_err_unstable = unstable_q;
   assign o_err_orphan   = orphan_q;
   assign o_err_ovf      = ovf_q;

endmodule

// File: tb/tb_axi4lite_stats.sv
// Bench for axi4lite_stats: directed scenarios with literal expectations plus a per-cycle
// comparison against an arithmetic model of the statistics.
module tb_axi4lite_stats;

   localparam int unsigned ADDR_W     = 16;
   localparam int unsigned DATA_BYTEW = 4;
   localparam int unsigned ID_W       = 4;
   localparam int unsigned CNT_W      = 4;
   localparam int unsigned OST_W      = 2;
   localparam int unsigned DATA_W     = 8 * DATA_BYTEW;
   localparam int          CMAX       = 15;
   localparam int          OMAX       = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr;
   logic [ID_W-1:0]       awid, bid, arid, rid;
   logic [ADDR_W-1:0]     awaddr, araddr;
   logic [2:0]            awprot, arprot;
   logic [DATA_W-1:0]     wdata, rdata;
   logic [DATA_BYTEW-1:0] wstrb;
   logic [1:0]            bresp, rresp;
   logic awvalid, awready, wvalid, wready, bvalid, bready;
   logic arvalid, arready, rvalid, rready;

   logic [5*CNT_W-1:0] o_cnt_tfr;
   logic [CNT_W-1:0]   o_cnt_berr, o_cnt_rerr;
   logic [OST_W-1:0]   o_wr_ost, o_rd_ost, o_wr_hwm, o_rd_hwm;
   logic [4:0]         o_err_vlddrop, o_err_unstable;
   logic [1:0]         o_err_orphan, o_err_ovf;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   axi4lite_stats #(
      .ADDR_W(ADDR_W), .DATA_BYTEW(DATA_BYTEW), .ID_W(ID_W), .CNT_W(CNT_W), .OST_W(OST_W)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr),
      .i_axi_awid(awid), .i_axi_awaddr(awaddr), .i_axi_awprot(awprot),
      .i_axi_awvalid(awvalid), .i_axi_awready(awready),
      .i_axi_wdata(wdata), .i_axi_wstrb(wstrb), .i_axi_wvalid(wvalid), .i_axi_wready(wready),
      .i_axi_bid(bid), .i_axi_bresp(bresp), .i_axi_bvalid(bvalid), .i_axi_bready(bready),
      .i_axi_arid(arid), .i_axi_araddr(araddr), .i_axi_arprot(arprot),
      .i_axi_arvalid(arvalid), .i_axi_arready(arready),
      .i_axi_rid(rid), .i_axi_rdata(rdata), .i_axi_rresp(rresp),
      .i_axi_rvalid(rvalid), .i_axi_rready(rready),
      .o_cnt_tfr(o_cnt_tfr), .o_cnt_berr(o_cnt_berr), .o_cnt_rerr(o_cnt_rerr),
      .o_wr_ost(o_wr_ost), .o_rd_ost(o_rd_ost), .o_wr_hwm(o_wr_hwm), .o_rd_hwm(o_rd_hwm),
      .o_err_vlddrop(o_err_vlddrop), .o_err_unstable(o_err_unstable),
      .o_err_orphan(o_err_orphan), .o_err_ovf(o_err_ovf)
   );

   task automatic chk(input string name, input logic [63:0] act, input longint exp);
      n_checks++;
      if (act !== 64'(exp)) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         m_cnt [5];
   int         m_berr, m_rerr, m_aw, m_w, m_rd, m_whwm, m_rhwm;
   bit [4:0]   m_drop, m_unst, m_stall;
   bit [1:0]   m_orph, m_ovf;
   logic [127:0] m_pl [5];

   function automatic logic [127:0] payload(input int k);
      logic [127:0] p;
      p = '0;
      case (k)
         0: p = 128'({awid, awaddr, awprot});
         1: p = 128'({wdata, wstrb});
         2: p = 128'({bid, bresp});
         3: p = 128'({arid, araddr, arprot});
         default: p = 128'({rid, rdata, rresp});
      endcase
      return p;
   endfunction

   function automatic int clamp(input int v, input int hi);
      return (v > hi) ? hi : v;
   endfunction

   // Model state advances on the same edge as the DUT, from the inputs held across it
   always @(posedge clk or negedge rst_n) begin
      bit [4:0] v, r, t, drop, unst;
      int aw_n, w_n, rd_n;
      bit b_orph, r_orph, w_ovf, r_ovf;
      if (!rst_n) begin
         for (int k = 0; k < 5; k++) begin
            m_cnt[k] = 0;
            m_pl[k]  = '0;
         end
         m_berr = 0; m_rerr = 0; m_aw = 0; m_w = 0; m_rd = 0; m_whwm = 0; m_rhwm = 0;
         m_drop = '0; m_unst = '0; m_stall = '0; m_orph = '0; m_ovf = '0;
      end else begin
         v = {rvalid, arvalid, bvalid, wvalid, awvalid};
         r = {rready, arready, bready, wready, awready};
         t = v & r;
         b_orph = t[2] && (m_aw == 0 || m_w == 0);
         r_orph = t[4] && (m_rd == 0);
         aw_n = m_aw + int'(t[0]) - ((t[2] && m_aw > 0) ? 1 : 0);
         w_n  = m_w + int'(t[1]) - ((t[2] && m_w > 0) ? 1 : 0);
         rd_n = m_rd + int'(t[3]) - ((t[4] && m_rd > 0) ? 1 : 0);
         w_ovf = (aw_n > OMAX) || (w_n > OMAX);
         r_ovf = rd_n > OMAX;
         m_aw = clamp(aw_n, OMAX);
         m_w  = clamp(w_n, OMAX);
         m_rd = clamp(rd_n, OMAX);
         for (int k = 0; k < 5; k++) begin
            drop[k] = m_stall[k] && !v[k];
            unst[k] = m_stall[k] && v[k] && (payload(k) != m_pl[k]);
            m_pl[k] = payload(k);
         end
         m_stall = v & ~r;
         if (clr) begin
            for (int k = 0; k < 5; k++) m_cnt[k] = 0;
            m_berr = 0; m_rerr = 0; m_whwm = 0; m_rhwm = 0;
            m_drop = '0; m_unst = '0; m_orph = '0; m_ovf = '0;
         end else begin
            for (int k = 0; k < 5; k++) m_cnt[k] = clamp(m_cnt[k] + int'(t[k]), CMAX);
            m_berr = clamp(m_berr + ((t[2] && bresp[1]) ? 1 : 0), CMAX);
            m_rerr = clamp(m_rerr + ((t[4] && rresp[1]) ? 1 : 0), CMAX);
            if (m_aw > m_whwm) m_whwm = m_aw;
            if (m_rd > m_rhwm) m_rhwm = m_rd;
            m_drop = m_drop | drop;
            m_unst = m_unst | unst;
            m_orph = m_orph | {r_orph, b_orph};
            m_ovf  = m_ovf | {r_ovf, w_ovf};
         end
      end
   end

   // Compare every output against the model on the falling edge
   always @(negedge clk) begin
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("model cnt_tfr[%0d]", k), 64'(o_cnt_tfr[k*CNT_W +: CNT_W]), m_cnt[k]);
      end
      chk("model cnt_berr", 64'(o_cnt_berr), m_berr);
      chk("model cnt_rerr", 64'(o_cnt_rerr), m_rerr);
      chk("model wr_ost", 64'(o_wr_ost), m_aw);
      chk("model rd_ost", 64'(o_rd_ost), m_rd);
      chk("model wr_hwm", 64'(o_wr_hwm), m_whwm);
      chk("model rd_hwm", 64'(o_rd_hwm), m_rhwm);
      chk("model vlddrop", 64'(o_err_vlddrop), longint'(m_drop));
      chk("model unstable", 64'(o_err_unstable), longint'(m_unst));
      chk("model orphan", 64'(o_err_orphan), longint'(m_orph));
      chk("model ovf", 64'(o_err_ovf), longint'(m_ovf));
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      clr = 1'b0;
      awid = '0; awaddr = '0; awprot = '0; awvalid = 1'b0; awready = 1'b0;
      wdata = '0; wstrb = '0; wvalid = 1'b0; wready = 1'b0;
      bid = '0; bresp = '0; bvalid = 1'b0; bready = 1'b0;
      arid = '0; araddr = '0; arprot = '0; arvalid = 1'b0; arready = 1'b0;
      rid = '0; rdata = '0; rresp = '0; rvalid = 1'b0; rready = 1'b0;
   endtask

   task automatic do_clear();
      idle();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   function automatic logic [63:0] cnt_of(input int k);
      return 64'(o_cnt_tfr[k*CNT_W +: CNT_W]);
   endfunction

   initial begin
      idle();
      repeat (3) step();
      chk("reset cnt_tfr", 64'(o_cnt_tfr), 0);
      chk("reset wr_hwm", 64'(o_wr_hwm), 0);
      rst_n = 1'b1;
      step();

      // Scenario 1: three writes, one error response
      for (int i = 0; i < 3; i++) begin
         awvalid = 1'b1; awready = 1'b1; awid = ID_W'(i); awaddr = ADDR_W'(32'h1000 + 16 * i);
         step();
      end
      idle();
      chk("s1 wr_ost peak", 64'(o_wr_ost), 3);
      for (int i = 0; i < 3; i++) begin
         wvalid = 1'b1; wready = 1'b1; wdata = DATA_W'(32'hA000 + i); wstrb = '1;
         step();
      end
      idle();
      for (int i = 0; i < 3; i++) begin
         bvalid = 1'b1; bready = 1'b1; bid = ID_W'(i); bresp = (i == 1) ? 2'b10 : 2'b00;
         step();
      end
      idle();
      chk("s1 cnt aw", cnt_of(0), 3);
      chk("s1 cnt w", cnt_of(1), 3);
      chk("s1 cnt b", cnt_of(2), 3);
      chk("s1 cnt_berr", 64'(o_cnt_berr), 1);
      chk("s1 wr_ost end", 64'(o_wr_ost), 0);
      chk("s1 wr_hwm", 64'(o_wr_hwm), 3);
      chk("s1 flags", 64'({o_err_vlddrop, o_err_unstable, o_err_orphan, o_err_ovf}), 0);
      do_clear();
      chk("clr cnt_tfr", 64'(o_cnt_tfr), 0);
      chk("clr wr_hwm", 64'(o_wr_hwm), 0);

      // Scenario 2: AR stalled with changing address, then VALID dropped
      arvalid = 1'b1; arready = 1'b0; arid = 4'h1; araddr = 16'h0100;
      step();
      araddr = 16'h0104;
      step();
      chk("s2 unstable", 64'(o_err_unstable), 64'h08);
      arvalid = 1'b0;
      step();
      chk("s2 vlddrop", 64'(o_err_vlddrop), 64'h08);
      chk("s2 rd_ost", 64'(o_rd_ost), 0);
      do_clear();

      // Scenario 3: R with nothing outstanding
      rvalid = 1'b1; rready = 1'b1; rid = 4'h2; rdata = 32'hDEAD_BEEF;
      step();
      idle();
      chk("s3 orphan", 64'(o_err_orphan), 2);
      chk("s3 rd_ost", 64'(o_rd_ost), 0);
      chk("s3 cnt r", cnt_of(4), 1);
      do_clear();

      // Scenario 4: read outstanding saturation, simultaneous AR+R, then drain
      for (int i = 0; i < 4; i++) begin
         arvalid = 1'b1; arready = 1'b1; araddr = ADDR_W'(32'h200 + 4 * i);
         step();
      end
      idle();
      chk("s4 rd_ost sat", 64'(o_rd_ost), 3);
      chk("s4 rd_hwm", 64'(o_rd_hwm), 3);
      chk("s4 ovf", 64'(o_err_ovf), 2);
      arvalid = 1'b1; arready = 1'b1; rvalid = 1'b1; rready = 1'b1;
      step();
      idle();
      chk("s4 rd_ost inc+dec", 64'(o_rd_ost), 3);
      for (int i = 0; i < 3; i++) begin
         rvalid = 1'b1; rready = 1'b1; rresp = (i == 0) ? 2'b11 : 2'b00;
         step();
      end
      idle();
      chk("s4 rd_ost drained", 64'(o_rd_ost), 0);
      chk("s4 cnt ar", cnt_of(3), 5);
      chk("s4 cnt r", cnt_of(4), 4);
      chk("s4 cnt_rerr", 64'(o_cnt_rerr), 1);
      chk("s4 orphan", 64'(o_err_orphan), 0);
      do_clear();

      // Scenario 5: W counter saturation, then clear during a transfer
      for (int i = 0; i < 17; i++) begin
         wvalid = 1'b1; wready = 1'b1; wdata = DATA_W'(i); wstrb = 4'hF;
         step();
      end
      chk("s5 cnt w sat", cnt_of(1), 15);
      chk("s5 ovf", 64'(o_err_ovf), 1);
      clr = 1'b1;
      step();
      idle();
      chk("s5 cnt w cleared", cnt_of(1), 0);
      chk("s5 ovf cleared", 64'(o_err_ovf), 0);

      // Scenario 6: asynchronous reset with reads outstanding
      for (int i = 0; i < 2; i++) begin
         arvalid = 1'b1; arready = 1'b1; araddr = ADDR_W'(32'h300 + 4 * i);
         step();
      end
      idle();
      chk("s6 rd_ost pre", 64'(o_rd_ost), 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("s6 async cnt_tfr", 64'(o_cnt_tfr), 0);
      chk("s6 async ost", 64'({o_wr_ost, o_rd_ost, o_wr_hwm, o_rd_hwm}), 0);
      chk("s6 async errcnt", 64'({o_cnt_berr, o_cnt_rerr}), 0);
      chk("s6 async flags", 64'({o_err_vlddrop, o_err_unstable, o_err_orphan, o_err_ovf}), 0);
      step();
      rst_n = 1'b1;
      rvalid = 1'b1; rready = 1'b1; rid = 4'h3;
      step();
      idle();
      chk("s6 orphan", 64'(o_err_orphan), 2);
      chk("s6 rd_ost", 64'(o_rd_ost), 0);
      chk("s6 cnt r", cnt_of(4), 1);

      // Scenario 7: B in the same cycle as the first AW is still an orphan
      awvalid = 1'b1; awready = 1'b1; bvalid = 1'b1; bready = 1'b1;
      step();
      idle();
      chk("s7 orphan", 64'(o_err_orphan), 3);
      chk("s7 wr_ost", 64'(o_wr_ost), 1);
      chk("s7 wr_hwm", 64'(o_wr_hwm), 1);

      repeat (2) step();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
